// File: rtl/bf_syndrome_sched.sv
// Iteration scheduler for the LDPC bit-flipping decoder: scans the syndrome through the shared
// popcount, accumulates its weight and decides between success, failure or another flip pass.
module bf_syndrome_sched #(
  parameter int unsigned NCHUNK   = 4,
  parameter int unsigned CHUNK_AW = 2,
  parameter int unsigned MAX_ITER = 20,
  parameter int unsigned ITER_W   = 5,
  parameter int unsigned WGT_W    = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                syn_rd_en,
  output logic [CHUNK_AW-1:0] syn_rd_addr,
  input  logic [255:0]        syn_rd_data,
  output logic [255:0]        pc_data,
  input  logic [8:0]          pc_sum,
  output logic                flip_req,
  input  logic                flip_done,
  output logic [ITER_W-1:0]   iter_cnt,
  output logic [WGT_W-1:0]    weight,
  output logic                done,
  output logic                success
);

  localparam logic [CHUNK_AW-1:0] LastAddr = CHUNK_AW'(NCHUNK - 1);
  localparam logic [ITER_W-1:0]   MaxIter  = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {StIdle, StScan, StWait, StDecide, StFlip} state_e;

  state_e              r_state, w_state_nxt;
  logic [CHUNK_AW-1:0] r_addr, w_addr_nxt;
  logic                r_vld;
  logic [WGT_W-1:0]    r_acc, w_acc_nxt;
  logic [WGT_W-1:0]    r_weight, w_weight_nxt;
  logic [ITER_W-1:0]   r_iter, w_iter_nxt;
  logic                r_success, w_success_nxt;
  logic                r_flip_first, w_flip_first_nxt;

  assign pc_data     = syn_rd_data;
  assign busy        = (r_state != StIdle);
  assign syn_rd_addr = r_addr;
  assign iter_cnt    = r_iter;
  assign weight      = r_weight;

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_acc_nxt        = r_vld ? (r_acc + {{(WGT_W-9){1'b0}}, pc_sum}) : r_acc;
    w_weight_nxt     = r_weight;
    w_iter_nxt       = r_iter;
    w_success_nxt    = r_success;
    w_flip_first_nxt = 1'b0;
    syn_rd_en        = 1'b0;
    flip_req         = 1'b0;
    done             = 1'b0;
    success          = r_success;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt   = StScan;
          w_addr_nxt    = '0;
          w_iter_nxt    = '0;
          w_acc_nxt     = '0;
          w_success_nxt = 1'b0;
        end
      end
      StScan: begin
        syn_rd_en = 1'b1;
        if (r_addr == LastAddr) begin
          w_state_nxt = StWait;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      StWait: begin
        // Leave only once the last chunk has been folded into the accumulator.
        if (!r_vld) begin
          w_state_nxt  = StDecide;
          w_weight_nxt = r_acc;
        end
      end
      StDecide: begin
        if (r_weight == '0) begin
          done          = 1'b1;
          success       = 1'b1;
          w_success_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end else if (r_iter == MaxIter) begin
          done          = 1'b1;
          success       = 1'b0;
          w_success_nxt = 1'b0;
          w_state_nxt   = StIdle;
        end else begin
          w_state_nxt      = StFlip;
          w_flip_first_nxt = 1'b1;
        end
      end
      StFlip: begin
        flip_req = r_flip_first;
        if (flip_done) begin
          w_iter_nxt  = r_iter + 1'b1;
          w_acc_nxt   = '0;
          w_addr_nxt  = '0;
          w_state_nxt = StScan;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_vld        <= 1'b0;
      r_acc        <= '0;
      r_weight     <= '0;
      r_iter       <= '0;
      r_success    <= 1'b0;
      r_flip_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_vld        <= syn_rd_en;
      r_acc        <= w_acc_nxt;
      r_weight     <= w_weight_nxt;
      r_iter       <= w_iter_nxt;
      r_success    <= w_success_nxt;
      r_flip_first <= w_flip_first_nxt;
    end
  end

endmodule

// File: tb/tb_bf_syndrome_sched.sv
// Scoreboard bench for bf_syndrome_sched: DUT0 uses MAX_ITER=20, DUT1 uses MAX_ITER=0.
module tb_bf_syndrome_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start0, start1;
  logic         busy0, en0, flip_req0, done0, success0;
  logic [1:0]   addr0;
  logic [255:0] rd0, pc_data0;
  logic [8:0]   pc_sum0;
  logic         flip_done0, flip_done0_a, man_flip;
  logic [4:0]   iter0;
  logic [10:0]  weight0;

  logic         busy1, en1, flip_req1, done1, success1, flip_done1;
  logic [1:0]   addr1;
  logic [255:0] rd1, pc_data1;
  logic [8:0]   pc_sum1;
  logic [4:0]   iter1;
  logic [10:0]  weight1;

  assign flip_done0 = flip_done0_a | man_flip;
  assign pc_sum0    = 9'($countones(pc_data0));
  assign pc_sum1    = 9'($countones(pc_data1));

  bf_syndrome_sched #(.NCHUNK(4), .CHUNK_AW(2), .MAX_ITER(20), .ITER_W(5), .WGT_W(11)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .syn_rd_en(en0),
    .syn_rd_addr(addr0), .syn_rd_data(rd0), .pc_data(pc_data0), .pc_sum(pc_sum0),
    .flip_req(flip_req0), .flip_done(flip_done0), .iter_cnt(iter0), .weight(weight0),
    .done(done0), .success(success0)
  );

  bf_syndrome_sched #(.NCHUNK(4), .CHUNK_AW(2), .MAX_ITER(0), .ITER_W(5), .WGT_W(11)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .syn_rd_en(en1),
    .syn_rd_addr(addr1), .syn_rd_data(rd1), .pc_data(pc_data1), .pc_sum(pc_sum1),
    .flip_req(flip_req1), .flip_done(flip_done1), .iter_cnt(iter1), .weight(weight1),
    .done(done1), .success(success1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic [255:0] mem0 [4];
  logic [255:0] mem1 [4];
  bit           clear_on_flip = 1'b0;
  bit           auto_flip = 1'b1;
  int           flip_dly = 3;
  int           fcnt = 0;
  int           n_flip_done = 0;
  int           clear_base = 0;
  int           flip_cnt = 0;
  logic [10:0]  exp_flip_w = '0;
  logic [1:0]   addr_log [$];

  typedef struct packed {
    logic        succ;
    logic [10:0] w;
    logic [4:0]  it;
  } exp_t;
  exp_t sb [$];

  // Syndrome memories with one-cycle read latency; the flip engine "clears" DUT0's syndrome.
  always @(posedge clk) begin
    if (en0) rd0 <= (clear_on_flip && n_flip_done > clear_base) ? '0 : mem0[addr0];
    if (en1) rd1 <= mem1[addr1];
  end

  always @(negedge clk) begin
    flip_done0_a = 1'b0;
    if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0 && auto_flip) begin
        flip_done0_a = 1'b1;
        n_flip_done++;
      end
    end
    if (flip_req0) fcnt = flip_dly;
  end

  always @(negedge clk) begin
    exp_t e;
    if (en0) addr_log.push_back(addr0);
    if (flip_req0) begin
      flip_cnt++;
      check("flip_weight", 32'(weight0), 32'(exp_flip_w));
    end
    if (done0) begin
      check("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("done_success", 32'(success0), 32'(e.succ));
        check("done_weight", 32'(weight0), 32'(e.w));
        check("done_iter", 32'(iter0), 32'(e.it));
      end
    end
  end

  task automatic wait_done0(input int budget, output int edges);
    bit hit = 1'b0;
    edges = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done0) begin
        hit = 1'b1;
        break;
      end
    end
    check("done0_seen", 32'(hit), 32'd1);
  endtask

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic load_mem0(input logic [255:0] c0, input logic [255:0] c1,
                           input logic [255:0] c2, input logic [255:0] c3);
    mem0[0] = c0; mem0[1] = c1; mem0[2] = c2; mem0[3] = c3;
    clear_base = n_flip_done;
    addr_log.delete();
    flip_cnt = 0;
  endtask

  initial begin
    int   edges;
    int   fl1;
    bit   hit;
    logic [255:0] ones;
    ones = '1;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; man_flip = 1'b0; flip_done1 = 1'b0;
    for (int i = 0; i < 4; i++) begin mem0[i] = '0; mem1[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_en", 32'(en0), 32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_flipreq", 32'(flip_req0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_success", 32'(success0), 32'd0);
    check("rst_iter", 32'(iter0), 32'd0);
    check("rst_weight", 32'(weight0), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);

    // Zero syndrome: success after exactly 6 edges, no flip
    load_mem0('0, '0, '0, '0);
    clear_on_flip = 1'b0;
    sb.push_back('{succ: 1'b1, w: 11'd0, it: 5'd0});
    pulse_start0();
    wait_done0(100, edges);
    check("zero_latency", 32'(edges), 32'd6);
    check("zero_flips", 32'(flip_cnt), 32'd0);
    check("zero_addr_n", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < addr_log.size(); i++)
      check($sformatf("zero_addr%0d", i), 32'(addr_log[i]), 32'(i % 4));

    // Weight 257, one flip clears it
    load_mem0(ones, 256'h1, '0, '0);
    clear_on_flip = 1'b1; flip_dly = 3; exp_flip_w = 11'd257;
    sb.push_back('{succ: 1'b1, w: 11'd0, it: 5'd1});
    pulse_start0();
    wait_done0(200, edges);
    check("one_flip_cnt", 32'(flip_cnt), 32'd1);

    // Never clears: give up after 20 passes
    load_mem0('0, '0, 256'hff, '0);
    clear_on_flip = 1'b0; exp_flip_w = 11'd8;
    sb.push_back('{succ: 1'b0, w: 11'd8, it: 5'd20});
    pulse_start0();
    wait_done0(3000, edges);
    check("limit_flip_cnt", 32'(flip_cnt), 32'd20);
    repeat (3) @(negedge clk);
    check("limit_succ_hold", 32'(success0), 32'd0);
    check("limit_iter_hold", 32'(iter0), 32'd20);
    check("limit_busy", 32'(busy0), 32'd0);

    // start while busy (SCAN and FLIP) is ignored
    load_mem0(ones, 256'h1, '0, '0);
    clear_on_flip = 1'b1; flip_dly = 5; exp_flip_w = 11'd257;
    sb.push_back('{succ: 1'b1, w: 11'd0, it: 5'd1});
    pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (flip_req0) begin hit = 1'b1; break; end
    end
    check("busy_flipreq_seen", 32'(hit), 32'd1);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done0(200, edges);
    check("busy_flip_cnt", 32'(flip_cnt), 32'd1);
    check("busy_addr_n", 32'(addr_log.size()), 32'd8);
    for (int i = 0; i < addr_log.size(); i++)
      check($sformatf("busy_addr%0d", i), 32'(addr_log[i]), 32'(i % 4));

    // Reset while in FLIP at iter 3; late flip_done must be ignored
    load_mem0('0, '0, 256'hff, '0);
    clear_on_flip = 1'b0; flip_dly = 3; exp_flip_w = 11'd8;
    pulse_start0();
    hit = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (flip_req0 && iter0 == 5'd3) begin hit = 1'b1; break; end
    end
    check("rstflip_reached", 32'(hit), 32'd1);
    auto_flip = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstflip_busy", 32'(busy0), 32'd0);
    check("rstflip_iter", 32'(iter0), 32'd0);
    check("rstflip_weight", 32'(weight0), 32'd0);
    check("rstflip_en", 32'(en0), 32'd0);
    man_flip = 1'b1;
    @(negedge clk);
    man_flip = 1'b0;
    @(negedge clk);
    check("rstflip_late_busy", 32'(busy0), 32'd0);
    check("rstflip_late_iter", 32'(iter0), 32'd0);
    check("rstflip_late_req", 32'(flip_req0), 32'd0);
    repeat (4) @(negedge clk);
    auto_flip = 1'b1;
    sb.delete();

    load_mem0('0, '0, '0, '0);
    sb.push_back('{succ: 1'b1, w: 11'd0, it: 5'd0});
    pulse_start0();
    wait_done0(100, edges);
    check("fresh_latency", 32'(edges), 32'd6);
    check("fresh_flips", 32'(flip_cnt), 32'd0);

    // MAX_ITER=0 with weight 5: immediate failure
    mem1[3] = 256'h1f;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    hit = 1'b0; fl1 = 0; edges = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (flip_req1) fl1++;
      if (done1) begin hit = 1'b1; break; end
    end
    check("mi0_done_seen", 32'(hit), 32'd1);
    check("mi0_latency", 32'(edges), 32'd6);
    check("mi0_success", 32'(success1), 32'd0);
    check("mi0_weight", 32'(weight1), 32'd5);
    check("mi0_iter", 32'(iter1), 32'd0);
    check("mi0_flips", 32'(fl1), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
